// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core types and constants for the fetch stage
package riscv_pkg;
    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    typedef enum logic {FETCH, DISCARD} fetch_state_t;
    typedef struct packed {
        logic [31:0] instr;
        logic [XLEN-1:0] pc;
    } queue_entry_t;
endpackage

// File: rtl/if_queue.sv
// if_queue: synchronous FIFO holding fetched instructions, flush beats push
module if_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input logic clk,
    input logic rst,
    input logic push,
    input logic pop,
    input logic flush,
    input logic [WIDTH-1:0] din,
    output logic full,
    output logic empty,
    output logic [WIDTH-1:0] head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rdPtr, wrPtr;
    logic doPush, doPop;
    assign doPush = push && !full;
    assign doPop = pop && !empty;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign head = mem[rdPtr];
    // pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk)
        if (rst || flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            wrPtr <= wrPtr + AW'(doPush);
            rdPtr <= rdPtr + AW'(doPop);
            count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
        end
    // entry storage needs no reset, occupancy decides what is visible
    always_ff @(posedge clk)
        if (doPush && !flush && !rst) mem[wrPtr] <= din;
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC, one-outstanding fetch FSM and decode-facing instruction queue
module if_fetch_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int DEPTH = 2
) (
    input logic clk,
    input logic rst,
    output logic imem_req,
    output logic [XLEN-1:0] imem_addr,
    input logic imem_valid,
    input logic [31:0] imem_rdata,
    input logic redirect,
    input logic [XLEN-1:0] redirect_pc,
    input logic stallD,
    output logic validD,
    output logic [31:0] instrD,
    output logic [XLEN-1:0] pcD,
    output logic [XLEN-1:0] pcPlus4D
);
    localparam int CW = $clog2(DEPTH) + 1;
    fetch_state_t state, stateNext;
    logic [XLEN-1:0] pc;
    logic full, empty, push, pop;
    logic [CW-1:0] count;
    queue_entry_t headEntry, pushEntry;
    assign imem_addr = pc;
    assign push = imem_req && imem_valid && !redirect && !full;
    assign pop = validD && !stallD;
    assign pushEntry = '{instr: imem_rdata, pc: pc};
    if_queue #(.DEPTH(DEPTH), .WIDTH($bits(queue_entry_t))) queue (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(pop),
        .flush(redirect),
        .din(pushEntry),
        .full(full),
        .empty(empty),
        .head(headEntry),
        .count(count)
    );
    // state register
    always_ff @(posedge clk)
        state <= rst ? FETCH : stateNext;
    // a redirect that catches a fetch in flight must swallow its late response
    always_comb
        stateNext = (state == FETCH) ? ((redirect && imem_req && !imem_valid) ? DISCARD : FETCH)
                                     : (imem_valid ? FETCH : DISCARD);
    // request and decode outputs, forced to their idle values while reset is held
    always_comb begin
        imem_req = !rst && state == FETCH && count < CW'(DEPTH);
        validD = !rst && !empty;
        instrD = validD ? headEntry.instr : NOP_INSTR;
        pcD = validD ? headEntry.pc : '0;
        pcPlus4D = validD ? headEntry.pc + XLEN'(4) : '0;
    end
    // program counter: redirect wins, otherwise advance on each accepted fetch
    always_ff @(posedge clk)
        if (rst) pc <= {RESET_PC[XLEN-1:2], 2'b00};
        else if (redirect) pc <= {redirect_pc[XLEN-1:2], 2'b00};
        else if (push) pc <= pc + XLEN'(4);
endmodule
